alu_seq_param: RTL and testbench
================================

Name: alu_seq_param

Overview:
- Parametrised, handshaked successor to the team's 16-bit registered ALU.
- Keeps the same 4-bit opcode map and the four class flags.
- Adds the following:
  - generic operand width
  - valid/ready input and output handshakes with output hold under backpressure
  - a multi-cycle iterative divider controlled by a state machine
  - an error flag
- Sits between the operand/decode stage and the writeback register in the datapath.

Parameters:
- WIDTH, 16: operand and result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1): width of the divider iteration counter. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- ALU_FUN  in  4  opcode.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- ALU_OUT  out  WIDTH  registered result.
- Arith_flag  out  1  registered; opcodes 0000-0011.
- Logic_flag  out  1  registered; opcodes 0100-1001.
- CMP_flag  out  1  registered; opcodes 1010-1100.
- Shift_flag  out  1  registered; opcodes 1101-1110.
- Err_flag  out  1  registered; divide by zero, or divide unsupported.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately, including mid-divide.
  - state=IDLE, out_valid=0, ALU_OUT=0, all flags=0, divider registers=0.
- Acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a clock edge where in_valid && in_ready.
- Opcode map (results truncated to WIDTH):
  - 0000 A+B; 0001 A-B (mod 2^WIDTH); 0010 A*B (low WIDTH bits); 0011 A/B (quotient).
  - 0100 AND; 0101 OR; 0110 NAND; 0111 NOR; 1000 XOR; 1001 XNOR.
  - 1010 A==B; 1011 A>B; 1100 A<B. Compare results are 1 or 0, zero-extended.
  - 1101 A>>1; 1110 A<<1. Logical shifts, zero fill.
  - 1111: result 0, all flags 0, still produces out_valid.
- Single-cycle ops (all except 0011 with B!=0):
  - Accepted at edge N; ALU_OUT, flags and out_valid=1 are visible after edge N.
  - Latency is 1.
- Divide, B!=0:
  - IDLE -> DIV on accept. Latch A, B, and the opcode flags; clear remainder; counter=WIDTH.
  - In DIV, one restoring-division step per cycle, most significant bit first; counter decrements.
  - When counter reaches 1, the final step is taken. Then: ALU_OUT=quotient, out_valid=1, state -> IDLE.
  - Latency is WIDTH cycles from accept to out_valid.
  - in_ready=0 throughout DIV.
- Divide, B==0:
  - Single cycle. ALU_OUT = all ones, Arith_flag=1, Err_flag=1.
- Output hold:
  - While out_valid && !out_ready, ALU_OUT and all flags hold stable and no new op is accepted.
  - A result is consumed on an edge with out_valid && out_ready.
  - If a new accept happens on the same edge as consume (back-to-back), the new single-cycle result replaces it with out_valid held at 1.
  - If that new op is a divide, out_valid drops to 0 until the divide completes.
- Err_flag is 0 for every result except the divide cases above.
- Exactly one class flag is 1 per valid result, except opcode 1111.
- Inputs are ignored whenever in_ready=0.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: the iterative divider and DIV state are built, as above.
- Undefined:
  - No divider logic and no DIV state.
  - Opcode 0011 completes in 1 cycle with ALU_OUT=0, Arith_flag=1, Err_flag=1.
  - in_ready depends only on out_valid/out_ready.

Test Plan:
- Reset, then in_valid with ALU_FUN=0000, A=16'hFFFF, B=1, out_ready=1:
  - next cycle out_valid=1, ALU_OUT=0, Arith_flag=1, others 0.
- ALU_DIV_EN defined, A=100, B=7, op 0011:
  - in_ready=0 for 16 cycles; ALU_OUT=14 after 16 cycles, Err_flag=0.
  - Then A=5, B=0, op 0011: after 1 cycle ALU_OUT=16'hFFFF, Err_flag=1.
- Backpressure: out_ready=0, op 1011 with A=9, B=3:
  - ALU_OUT=1, CMP_flag=1, held for 5 cycles; in_ready=0 throughout.
  - Raise out_ready with a new op 1101, A=16'h8001, accepted the same edge: next ALU_OUT=16'h4000, Shift_flag=1.
- Assert rst at cycle 5 of a divide:
  - out_valid=0, ALU_OUT=0, flags 0 immediately.
  - After release, in_ready=1 and op 0100 with A=16'hF0F0, B=16'h0FF0 gives 16'h00F0 in 1 cycle.
- WIDTH=8, op 0010 with A=8'h20, B=8'h10:
  - ALU_OUT=8'h00 (truncated), Arith_flag=1.
  - Op 1111: ALU_OUT=0, all flags 0, out_valid=1.

Source files
------------

// File: rtl/alu_seq_param.sv
// alu_seq_param: parametrised handshaked ALU with valid/ready on both sides.
// Define ALU_DIV_EN to build the multi-cycle restoring divider for opcode 0011.
`default_nettype none

module alu_seq_param #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_FUN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic             Arith_flag,
   output logic             Logic_flag,
   output logic             CMP_flag,
   output logic             Shift_flag,
   output logic             Err_flag
);

   // Flag vector layout: {arith, logic, cmp, shift, err}
   localparam logic [4:0] F_ARITH = 5'b10000;
   localparam logic [4:0] F_LOGIC = 5'b01000;
   localparam logic [4:0] F_CMP   = 5'b00100;
   localparam logic [4:0] F_SHIFT = 5'b00010;
   localparam logic [4:0] F_AERR  = 5'b10001;

   logic             out_valid_q, out_valid_n;
   logic [WIDTH-1:0] alu_out_q, alu_out_n;
   logic [4:0]       flags_q, flags_n;
   logic [WIDTH-1:0] res;
   logic [4:0]       res_flags;
   logic             accept;

`ifdef ALU_DIV_EN
   typedef enum logic [0:0] {IDLE = 1'b0, DIV = 1'b1} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] quo_q, quo_n;
   logic [WIDTH-1:0] dvs_q, dvs_n;
   logic [WIDTH-1:0] rem_q, rem_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] quo_step;
   logic [WIDTH-1:0] rem_step;

   assign in_ready = (state == IDLE) && (!out_valid_q || out_ready);

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   assign shifted  = {rem_q, quo_q[WIDTH-1]};
   assign diff     = shifted - {1'b0, dvs_q};
   assign quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
   assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
`else
   assign in_ready = !out_valid_q || out_ready;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      res       = '0;
      res_flags = '0;
      case (ALU_FUN)
         4'b0000: begin res = A + B;  res_flags = F_ARITH; end
         4'b0001: begin res = A - B;  res_flags = F_ARITH; end
         4'b0010: begin res = A * B;  res_flags = F_ARITH; end
         4'b0011: begin
`ifdef ALU_DIV_EN
            res       = (B == '0) ? '1 : '0;
            res_flags = (B == '0) ? F_AERR : F_ARITH;
`else
            res       = '0;
            res_flags = F_AERR;
`endif
         end
         4'b0100: begin res = A & B;     res_flags = F_LOGIC; end
         4'b0101: begin res = A | B;     res_flags = F_LOGIC; end
         4'b0110: begin res = ~(A & B);  res_flags = F_LOGIC; end
         4'b0111: begin res = ~(A | B);  res_flags = F_LOGIC; end
         4'b1000: begin res = A ^ B;     res_flags = F_LOGIC; end
         4'b1001: begin res = ~(A ^ B);  res_flags = F_LOGIC; end
         4'b1010: begin res = {{(WIDTH-1){1'b0}}, (A == B)}; res_flags = F_CMP; end
         4'b1011: begin res = {{(WIDTH-1){1'b0}}, (A > B)};  res_flags = F_CMP; end
         4'b1100: begin res = {{(WIDTH-1){1'b0}}, (A < B)};  res_flags = F_CMP; end
         4'b1101: begin res = A >> 1; res_flags = F_SHIFT; end
         4'b1110: begin res = A << 1; res_flags = F_SHIFT; end
         default: begin res = '0;     res_flags = '0;      end
      endcase
   end

   always_comb begin
      out_valid_n = out_valid_q && !out_ready;
      alu_out_n   = alu_out_q;
      flags_n     = flags_q;
`ifdef ALU_DIV_EN
      state_n = state;
      quo_n   = quo_q;
      dvs_n   = dvs_q;
      rem_n   = rem_q;
      cnt_n   = cnt_q;
      if (accept && ALU_FUN == 4'b0011 && B != '0) begin
         state_n     = DIV;
         out_valid_n = 1'b0;
         quo_n       = A;
         dvs_n       = B;
         rem_n       = '0;
         cnt_n       = CNT_W'(WIDTH);
      end else if (accept) begin
         out_valid_n = 1'b1;
         alu_out_n   = res;
         flags_n     = res_flags;
      end
      if (state == DIV) begin
         quo_n = quo_step;
         rem_n = rem_step;
         cnt_n = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_n     = IDLE;
            out_valid_n = 1'b1;
            alu_out_n   = quo_step;
            flags_n     = F_ARITH;
         end
      end
`else
      if (accept) begin
         out_valid_n = 1'b1;
         alu_out_n   = res;
         flags_n     = res_flags;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         flags_q     <= '0;
`ifdef ALU_DIV_EN
         state <= IDLE;
         quo_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_n;
         alu_out_q   <= alu_out_n;
         flags_q     <= flags_n;
`ifdef ALU_DIV_EN
         state <= state_n;
         quo_q <= quo_n;
         dvs_q <= dvs_n;
         rem_q <= rem_n;
         cnt_q <= cnt_n;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign ALU_OUT   = alu_out_q;
   assign {Arith_flag, Logic_flag, CMP_flag, Shift_flag, Err_flag} = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed plus random checks of alu_seq_param against a
// transaction-level reference model (16-bit and 8-bit instances).
`default_nettype none

module tb_alu_seq_param;

`ifdef ALU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready, in_ready, out_valid;
   logic [15:0] A, B, ALU_OUT;
   logic [3:0]  ALU_FUN;
   logic        Arith_flag, Logic_flag, CMP_flag, Shift_flag, Err_flag;

   logic        in_valid8, out_ready8, in_ready8, out_valid8;
   logic [7:0]  A8, B8, ALU_OUT8;
   logic [3:0]  ALU_FUN8;
   logic        Arith8, Logic8, CMP8, Shift8, Err8;

   int n_checks = 0;
   int n_fails  = 0;

   // Transaction-level model of the 16-bit instance
   bit          m_valid;
   logic [63:0] m_out, m_pend;
   logic [4:0]  m_flags;
   int          busy;

   always #5 clk = ~clk;

   alu_seq_param #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALU_FUN(ALU_FUN), .out_valid(out_valid), .out_ready(out_ready),
      .ALU_OUT(ALU_OUT), .Arith_flag(Arith_flag), .Logic_flag(Logic_flag),
      .CMP_flag(CMP_flag), .Shift_flag(Shift_flag), .Err_flag(Err_flag)
   );

   alu_seq_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .A(A8), .B(B8), .ALU_FUN(ALU_FUN8), .out_valid(out_valid8), .out_ready(out_ready8),
      .ALU_OUT(ALU_OUT8), .Arith_flag(Arith8), .Logic_flag(Logic8),
      .CMP_flag(CMP8), .Shift_flag(Shift8), .Err_flag(Err8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected result/flags {arith,logic,cmp,shift,err} for a w-bit single-cycle op.
   function automatic void ref_op(input int w, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r,
                                  output logic [4:0] f);
      logic [63:0] m;
      m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      r = 0;
      f = 5'b00000;
      case (op)
         4'd0:  begin r = (a + b) & m; f = 5'b10000; end
         4'd1:  begin r = (a - b) & m; f = 5'b10000; end
         4'd2:  begin r = (a * b) & m; f = 5'b10000; end
         4'd3:  begin
            if (DIV_EN && b != 0) begin r = a / b; f = 5'b10000; end
            else if (DIV_EN)      begin r = m;     f = 5'b10001; end
            else                  begin r = 0;     f = 5'b10001; end
         end
         4'd4:  begin r = a & b;        f = 5'b01000; end
         4'd5:  begin r = a | b;        f = 5'b01000; end
         4'd6:  begin r = ~(a & b) & m; f = 5'b01000; end
         4'd7:  begin r = ~(a | b) & m; f = 5'b01000; end
         4'd8:  begin r = a ^ b;        f = 5'b01000; end
         4'd9:  begin r = ~(a ^ b) & m; f = 5'b01000; end
         4'd10: begin r = (a == b) ? 1 : 0; f = 5'b00100; end
         4'd11: begin r = (a > b)  ? 1 : 0; f = 5'b00100; end
         4'd12: begin r = (a < b)  ? 1 : 0; f = 5'b00100; end
         4'd13: begin r = a >> 1;       f = 5'b00010; end
         4'd14: begin r = (a << 1) & m; f = 5'b00010; end
         default: begin r = 0;          f = 5'b00000; end
      endcase
   endfunction

   // One clock on the 16-bit instance: drive, check in_ready, clock, update model, check outputs.
   task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic ordy);
      logic        exp_rdy;
      logic [63:0] r;
      logic [4:0]  f;
      in_valid = iv; A = a; B = b; ALU_FUN = op; out_ready = ordy;
      #1;
      exp_rdy = (busy == 0) && (!m_valid || ordy);
      check("in_ready", in_ready, exp_rdy);
      @(posedge clk); #1;
      if (busy > 0) begin
         busy--;
         if (busy == 0) begin m_valid = 1; m_out = m_pend; m_flags = 5'b10000; end
      end else if (iv && exp_rdy) begin
         if (DIV_EN && op == 4'd3 && b != 0) begin
            busy = 16; m_valid = 0; m_pend = 64'(a) / 64'(b);
         end else begin
            ref_op(16, op, 64'(a), 64'(b), r, f);
            m_valid = 1; m_out = r; m_flags = f;
         end
      end else if (m_valid && ordy) begin
         m_valid = 0;
      end
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
         check("alu_out", ALU_OUT, m_out);
         check("flags", {Arith_flag, Logic_flag, CMP_flag, Shift_flag, Err_flag}, m_flags);
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      logic [63:0] r;
      logic [4:0]  f;
      in_valid8 = 1; A8 = a; B8 = b; ALU_FUN8 = op; out_ready8 = 1;
      #1;
      check("in_ready8", in_ready8, 1'b1);
      @(posedge clk); #1;
      in_valid8 = 0;
      ref_op(8, op, 64'(a), 64'(b), r, f);
      check("out_valid8", out_valid8, 1'b1);
      check("alu_out8", ALU_OUT8, r);
      check("flags8", {Arith8, Logic8, CMP8, Shift8, Err8}, f);
   endtask

   initial begin
      rst = 1; in_valid = 0; out_ready = 1; A = 0; B = 0; ALU_FUN = 0;
      in_valid8 = 0; out_ready8 = 1; A8 = 0; B8 = 0; ALU_FUN8 = 0;
      m_valid = 0; m_out = 0; m_pend = 0; m_flags = 0; busy = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_alu_out", ALU_OUT, 16'h0);
      check("rst_flags", {Arith_flag, Logic_flag, CMP_flag, Shift_flag, Err_flag}, 5'b0);
      check("rst_out_valid8", out_valid8, 1'b0);
      rst = 0;

      // Add wraps to zero
      cycle(1, 16'hFFFF, 16'h0001, 4'b0000, 1);
      cycle(0, 0, 0, 0, 1);

      // Divide with non-zero divisor, then divide by zero
      cycle(1, 16'd100, 16'd7, 4'b0011, 1);
      repeat (16) cycle(0, 0, 0, 0, 1);
      check("div_result", ALU_OUT, DIV_EN ? 16'd14 : 16'd0);
      cycle(1, 16'd5, 16'd0, 4'b0011, 1);
      check("div0_result", ALU_OUT, DIV_EN ? 16'hFFFF : 16'h0000);
      check("div0_err", Err_flag, 1'b1);
      cycle(0, 0, 0, 0, 1);

      // Backpressure: result held, new inputs ignored
      cycle(1, 16'd9, 16'd3, 4'b1011, 0);
      repeat (5) cycle(1, 16'($urandom), 16'($urandom), 4'($urandom), 0);
      check("held_cmp", {ALU_OUT, CMP_flag}, {16'd1, 1'b1});
      cycle(1, 16'h8001, 16'h0, 4'b1101, 1);
      check("shift_b2b", ALU_OUT, 16'h4000);

      // Back-to-back into a divide drops out_valid until completion
      cycle(1, 16'd3, 16'd4, 4'b0000, 0);
      cycle(1, 16'hBEEF, 16'd16, 4'b0011, 1);
      repeat (16) cycle(0, 0, 0, 0, 1);

      // Asynchronous reset mid-divide
      cycle(1, 16'd1000, 16'd3, 4'b0011, 1);
      repeat (4) cycle(0, 0, 0, 0, 1);
      #2 rst = 1;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_alu_out", ALU_OUT, 16'h0);
      check("arst_flags", {Arith_flag, Logic_flag, CMP_flag, Shift_flag, Err_flag}, 5'b0);
      @(posedge clk); #2;
      rst = 0;
      m_valid = 0; busy = 0;
      @(posedge clk); #1;
      cycle(1, 16'hF0F0, 16'h0FF0, 4'b0100, 1);
      check("and_after_rst", ALU_OUT, 16'h00F0);

      // Random traffic, including divides and backpressure
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom_range(0, 7) == 0 ? 0 : $urandom),
               4'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      cycle(0, 0, 0, 0, 1);
      repeat (17) cycle(0, 0, 0, 0, 1);

      // 8-bit instance: truncation, reserved opcode, random single-cycle ops
      op8(8'h20, 8'h10, 4'b0010);
      op8(8'h00, 8'h00, 4'b1111);
      op8(8'hFF, 8'h01, 4'b0000);
      op8(8'h81, 8'h00, 4'b1110);
      for (int i = 0; i < 20; i++) begin
         logic [3:0] op;
         op = 4'($urandom);
         if (op == 4'd3) op = 4'd1;
         op8(8'($urandom), 8'($urandom), op);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
